wash_phase_timer: RTL and testbench

Phase timer that generates the `cycletime_out` and `spintime_out` inputs of the washing-machine controller FSM. It watches the controller's actuator outputs (`motor_on`, `soap_wash`, `water_wash`, `drainvalve_on`), times each wash and spin phase against programmed durations using a clock prescaler, and returns timeout levels to the controller. It sits directly beside the controller in a closed loop: it consumes controller outputs and feeds controller inputs.

---
 rtl/wash_phase_timer.sv | 150 +++++++++++++++
 tb/tb_wash_phase_timer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/wash_phase_timer.sv
// wash_phase_timer: times the wash/rinse and spin phases of the washing-machine
// controller and returns level timeout flags to it.
// Optional build macro: WASH_TIMER_REMAIN_EN adds the remain_secs output.
module wash_phase_timer #(
    parameter int PRESCALE = 100,
    parameter int SEC_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             motor_on,
    input  logic             soap_wash,
    input  logic             water_wash,
    input  logic             drainvalve_on,
    input  logic             doorclose,
    input  logic [SEC_W-1:0] wash_secs,
    input  logic [SEC_W-1:0] spin_secs,
    output logic             cycletime_out,
    output logic             spintime_out
`ifdef WASH_TIMER_REMAIN_EN
    ,
    output logic [SEC_W-1:0] remain_secs
`endif
);

    localparam int             PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(PRESCALE - 1);

    typedef enum logic [2:0] {
        IDLE,
        WASH,
        WASH_EXP,
        SPIN,
        SPIN_EXP
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic [SEC_W-1:0] dur_q, dur_d;
    logic             cycletime_q, cycletime_d;
    logic             spintime_q, spintime_d;
    logic             water_q, soap_q;

    logic             wash_c, spin_c, in_wash, in_spin, wash_rise;
    logic [SEC_W-1:0] sec_inc;

    // Decode phase conditions and the soap/rinse restart edge from controller outputs.
    always_comb begin
        wash_c    = motor_on & (soap_wash | water_wash);
        spin_c    = motor_on & drainvalve_on & ~wash_c;
        in_wash   = (state_q == WASH) || (state_q == WASH_EXP);
        in_spin   = (state_q == SPIN) || (state_q == SPIN_EXP);
        wash_rise = (water_wash & ~water_q) | (soap_wash & ~soap_q);
        // Seconds counter sticks at all-ones rather than wrapping.
        sec_inc   = (sec_q == '1) ? sec_q : sec_q + SEC_W'(1);
    end

    // Next-state, counter and timeout-flag logic.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d = state_q;
        presc_d = presc_q;
        sec_d   = sec_q;
        dur_d   = dur_q;

        if (wash_c && (!in_wash || wash_rise)) begin
            // New wash phase, or soap->rinse restart of the running one.
            state_d = WASH;
            dur_d   = (wash_secs == '0) ? SEC_W'(1) : wash_secs;
            presc_d = '0;
            sec_d   = '0;
        end else if (spin_c && !in_spin) begin
            state_d = SPIN;
            dur_d   = (spin_secs == '0) ? SEC_W'(1) : spin_secs;
            presc_d = '0;
            sec_d   = '0;
        end else if (!wash_c && !spin_c) begin
            state_d = IDLE;
            presc_d = '0;
            sec_d   = '0;
        end else if (((state_q == WASH) || (state_q == SPIN)) && doorclose) begin
            // Condition still matches the running phase: advance time unless paused.
            if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                sec_d   = sec_inc;
                if (sec_inc >= dur_q) begin
                    state_d = (state_q == WASH) ? WASH_EXP : SPIN_EXP;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        cycletime_d = (state_d == WASH_EXP);
        spintime_d  = (state_d == SPIN_EXP);
    end

    // State, counters, latched duration, flags and edge-detect registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            sec_q       <= '0;
            dur_q       <= SEC_W'(1);
            cycletime_q <= 1'b0;
            spintime_q  <= 1'b0;
            water_q     <= 1'b0;
            soap_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q     <= state_d;
            presc_q     <= presc_d;
            sec_q       <= sec_d;
            dur_q       <= dur_d;
            cycletime_q <= cycletime_d;
            spintime_q  <= spintime_d;
            water_q     <= water_wash;
            soap_q      <= soap_wash;
        end
    end

    assign cycletime_out = cycletime_q;
    assign spintime_out  = spintime_q;

`ifdef WASH_TIMER_REMAIN_EN
    logic [SEC_W-1:0] remain_q, remain_d;

    // Seconds left in an active phase, updated together with the seconds counter.
    always_comb begin
        remain_d = '0;
        if ((state_d == WASH) || (state_d == SPIN)) begin
            remain_d = dur_d - sec_d;
        end
    end

    // Remaining-time register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remain_q <= '0;
        end else begin
            remain_q <= remain_d;
        end
    end

    assign remain_secs = remain_q;
`else
    // No remaining-time output in this build.
`endif

endmodule

// File: tb/tb_wash_phase_timer.sv
// Self-checking bench for wash_phase_timer (PRESCALE=4): directed vector table,
// hand-written restart/reset sequences, and random stimulus against a model.
module tb_wash_phase_timer;

    localparam int P     = 4;
    localparam int SEC_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             motor_on, soap_wash, water_wash, drainvalve_on, doorclose;
    logic [SEC_W-1:0] wash_secs, spin_secs;
    logic             cycletime_out, spintime_out;
`ifdef WASH_TIMER_REMAIN_EN
    logic [SEC_W-1:0] remain_secs;
`endif

    int checks = 0;
    int errors = 0;

    wash_phase_timer #(.PRESCALE(P), .SEC_W(SEC_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .motor_on      (motor_on),
        .soap_wash     (soap_wash),
        .water_wash    (water_wash),
        .drainvalve_on (drainvalve_on),
        .doorclose     (doorclose),
        .wash_secs     (wash_secs),
        .spin_secs     (spin_secs),
        .cycletime_out (cycletime_out),
        .spintime_out  (spintime_out)
`ifdef WASH_TIMER_REMAIN_EN
        ,
        .remain_secs   (remain_secs)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: a phase kind plus a count of active (door-closed) cycles
    // since phase start; the phase is expired once that count reaches N*P.
    int m_kind;     // 0 none, 1 wash, 2 spin
    int m_n;
    int m_elapsed;
    bit m_wprev, m_sprev;

    task automatic model_reset();
        m_kind = 0; m_n = 1; m_elapsed = 0; m_wprev = 0; m_sprev = 0;
    endtask

    task automatic model_step();
        bit wc, sc, rise;
        wc   = motor_on & (soap_wash | water_wash);
        sc   = motor_on & drainvalve_on & ~wc;
        rise = (water_wash & ~m_wprev) | (soap_wash & ~m_sprev);
        if (wc && (m_kind != 1 || rise)) begin
            m_kind = 1; m_n = (wash_secs == 0) ? 1 : int'(wash_secs); m_elapsed = 0;
        end else if (sc && m_kind != 2) begin
            m_kind = 2; m_n = (spin_secs == 0) ? 1 : int'(spin_secs); m_elapsed = 0;
        end else if (!wc && !sc) begin
            m_kind = 0;
        end else if (doorclose && m_elapsed < m_n * P) begin
            m_elapsed++;
        end
        m_wprev = water_wash;
        m_sprev = soap_wash;
    endtask

    function automatic bit m_expired();
        return (m_kind != 0) && (m_elapsed >= m_n * P);
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // One clock: advance the model on the inputs the DUT samples, then compare.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("model_cycletime", int'(cycletime_out), int'(m_kind == 1 && m_expired()));
        check("model_spintime",  int'(spintime_out),  int'(m_kind == 2 && m_expired()));
`ifdef WASH_TIMER_REMAIN_EN
        check("model_remain", int'(remain_secs),
              (m_kind != 0 && !m_expired()) ? m_n - m_elapsed / P : 0);
`endif
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_in(input bit m, input bit s, input bit w, input bit d, input bit door,
                          input int ws, input int ss);
        motor_on = m; soap_wash = s; water_wash = w; drainvalve_on = d; doorclose = door;
        wash_secs = SEC_W'(ws); spin_secs = SEC_W'(ss);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #12;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit motor, soap, water, drain, door;
        int ws, ss;
        int cycles;
        bit exp_cyc, exp_spin;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // Directed vectors: each row is held for 'cycles' edges, then checked.
        vecs.push_back('{0,0,0,0,1, 3,2,  2, 0,0});  // idle
        vecs.push_back('{1,1,0,0,1, 3,2, 11, 0,0});  // wash E0..E0+10
        vecs.push_back('{1,1,0,0,1, 3,2,  1, 0,0});  // E0+11
        vecs.push_back('{1,1,0,0,1, 3,2,  1, 1,0});  // E0+12 expiry
        vecs.push_back('{1,1,0,0,1, 3,2,  3, 1,0});  // held
        vecs.push_back('{1,0,0,0,1, 3,2,  1, 0,0});  // soap drop -> falls
        vecs.push_back('{1,0,0,1,1, 3,2,  7, 0,0});  // spin E0..E0+6
        vecs.push_back('{1,0,0,1,1, 3,2,  1, 0,0});  // E0+7
        vecs.push_back('{1,0,0,1,1, 3,2,  1, 0,1});  // E0+8 spin expiry
        vecs.push_back('{1,1,0,1,1, 1,2,  1, 0,0});  // wash wins, direct switch
        vecs.push_back('{1,1,0,1,1, 1,2,  3, 0,0});  // E0+3
        vecs.push_back('{1,1,0,1,1, 1,2,  1, 1,0});  // E0+4
        vecs.push_back('{0,0,0,0,1, 1,2,  1, 0,0});
        vecs.push_back('{1,1,0,0,1, 3,2,  5, 0,0});  // pause test E0..E0+4
        vecs.push_back('{1,1,0,0,0, 3,2,  5, 0,0});  // door open 5 cycles
        vecs.push_back('{1,1,0,0,1, 3,2,  7, 0,0});  // E0+16
        vecs.push_back('{1,1,0,0,1, 3,2,  1, 1,0});  // E0+17
        vecs.push_back('{0,0,0,0,1, 3,2,  1, 0,0});
        vecs.push_back('{1,1,0,0,1, 0,2,  4, 0,0});  // zero duration E0..E0+3
        vecs.push_back('{1,1,0,0,1, 0,2,  1, 1,0});  // E0+4
        vecs.push_back('{0,0,0,0,1, 0,2,  1, 0,0});

        set_in(0, 0, 0, 0, 1, 3, 2);
        rst = 1'b1;
        model_reset();
        #3;
        check("reset_cycletime", int'(cycletime_out), 0);
        check("reset_spintime",  int'(spintime_out),  0);
`ifdef WASH_TIMER_REMAIN_EN
        check("reset_remain", int'(remain_secs), 0);
`endif
        do_reset();

        foreach (vecs[k]) begin
            set_in(vecs[k].motor, vecs[k].soap, vecs[k].water, vecs[k].drain,
                   vecs[k].door, vecs[k].ws, vecs[k].ss);
            ticks(vecs[k].cycles);
            check($sformatf("vec%0d_cycletime", k), int'(cycletime_out), int'(vecs[k].exp_cyc));
            check($sformatf("vec%0d_spintime",  k), int'(spintime_out),  int'(vecs[k].exp_spin));
        end

        // Soap -> rinse restart: switch at Er, expiry at Er+12 and not earlier.
        do_reset();
        set_in(1, 1, 0, 0, 1, 3, 2);
        ticks(5);
        set_in(1, 0, 1, 0, 1, 3, 2);
        ticks(12);  // Er .. Er+11
        check("restart_early", int'(cycletime_out), 0);
        tick();     // Er+12
        check("restart_expiry", int'(cycletime_out), 1);
        set_in(0, 0, 0, 0, 1, 3, 2);
        tick();

`ifdef WASH_TIMER_REMAIN_EN
        // Remaining seconds step 3,2,1 every 4 cycles, then 0 when expired.
        set_in(1, 1, 0, 0, 1, 3, 2);
        tick();
        check("remain_e0", int'(remain_secs), 3);
        ticks(4);
        check("remain_e4", int'(remain_secs), 2);
        ticks(4);
        check("remain_e8", int'(remain_secs), 1);
        ticks(4);
        check("remain_e12", int'(remain_secs), 0);
        set_in(0, 0, 0, 0, 1, 3, 2);
        tick();
`endif

        // Asynchronous reset mid-phase, then restart from the first edge after release.
        set_in(1, 1, 0, 0, 1, 0, 2);
        ticks(5);   // E0..E0+4
        check("zero_dur_expiry", int'(cycletime_out), 1);
        tick();     // E0+5
        rst = 1'b1;
        #2;
        check("async_reset_out", int'(cycletime_out), 0);
        @(posedge clk);
        #1;
        check("reset_held_out", int'(cycletime_out), 0);
        rst = 1'b0;
        model_reset();
        ticks(4);   // E0'..E0'+3
        check("post_reset_early", int'(cycletime_out), 0);
        tick();     // E0'+4
        check("post_reset_expiry", int'(cycletime_out), 1);

        // Random stimulus with slowly changing inputs, checked every cycle.
        do_reset();
        set_in(1, 0, 0, 0, 1, 2, 1);
        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(0, 19) == 0) motor_on      = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 24) == 0) soap_wash     = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 24) == 0) water_wash    = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 19) == 0) drainvalve_on = $urandom_range(0, 1) != 0;
            doorclose = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) wash_secs = SEC_W'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) spin_secs = SEC_W'($urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
